// File: rtl/magcomp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// three-way verdict, plus conversions to and from the c0/c1/c2 flag triple.
package magcomp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    GT,
    EQ,
    LT
  } verdict_t;

  // Flags arrive as {lt, eq, gt} == {c2, c1, c0}; anything not cleanly one-hot reads as EQ.
  function automatic verdict_t verdict_from_flags(input logic gt, input logic eq, input logic lt);
    verdict_t v;
    case ({lt, eq, gt})
      3'b001:  v = GT;
      3'b100:  v = LT;
      default: v = EQ;
    endcase
    return v;
  endfunction

  // Returns {c2, c1, c0}.
  function automatic logic [2:0] verdict_onehot(input verdict_t v);
    logic [2:0] c;
    case (v)
      GT:      c = 3'b001;
      EQ:      c = 3'b010;
      LT:      c = 3'b100;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/magnitudecomp2bit.sv
// Combinational 2-bit magnitude comparator: c0 = a>b, c1 = a==b, c2 = a<b.
module magnitudecomp2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       c0,
  output logic       c1,
  output logic       c2
);

  assign c0 = (a > b);
  assign c1 = (a == b);
  assign c2 = (a < b);

endmodule

// File: rtl/magcomp_serial_cascade.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans operands MSB digit first
// through a 2-bit comparator and stops at the first unequal digit.
module magcomp_serial_cascade
  import magcomp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             c0,
  output logic             c1,
  output logic             c2
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("magcomp_serial_cascade: WIDTH must be even and >= 2");
  end

  state_t          state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CW-1:0]    cnt_q;
  verdict_t         verdict_q;
  verdict_t         verdict_d;
  verdict_t         digit_v;
  logic             done_q;
  logic [2:0]       c_q;
  logic             dgt;
  logic             deq;
  logic             dlt;

  magnitudecomp2bit u_digit (
    .a  (sa_q[WIDTH-1 -: 2]),
    .b  (sb_q[WIDTH-1 -: 2]),
    .c0 (dgt),
    .c1 (deq),
    .c2 (dlt)
  );

  always_comb begin
    digit_v   = verdict_from_flags(dgt, deq, dlt);
    verdict_d = (verdict_q == EQ) ? digit_v : verdict_q;
  end

  // done and c0..c2 are loaded on the RUN->DONE edge so they are valid throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      verdict_q <= EQ;
      done_q    <= 1'b0;
      c_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sa_q      <= a;
            sb_q      <= b;
            cnt_q     <= CW'(DIGITS - 1);
            verdict_q <= EQ;
            state_q   <= RUN;
          end
        end
        RUN: begin
          sa_q      <= sa_q << 2;
          sb_q      <= sb_q << 2;
          verdict_q <= verdict_d;
          if ((digit_v != EQ) || (cnt_q == '0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            c_q     <= verdict_onehot(verdict_d);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign c0   = c_q[0];
  assign c1   = c_q[1];
  assign c2   = c_q[2];

endmodule

// File: tb/tb_magcomp_serial_cascade.sv
// Scoreboard bench for magcomp_serial_cascade (WIDTH=8): the driver queues the
// expected verdict and latency per accepted start; a monitor checks each done.
module tb_magcomp_serial_cascade;

  localparam int unsigned W = 8;
  localparam int unsigned D = W / 2;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         c0;
  logic         c1;
  logic         c2;

  magcomp_serial_cascade #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  c;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [2:0]  held = 3'b000;
  int unsigned bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      bcnt = 0;
      held = 3'b000;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("verdict", {29'd0, c2, c1, c0}, {29'd0, e.c});
          chk("onehot", {31'd0, $onehot({c2, c1, c0})}, 32'd1);
          chk("latency", cyc - e.t0, e.lat);
          chk("busy_cycles", bcnt, e.lat + 1);
        end
        held = {c2, c1, c0};
        bcnt = 0;
      end else begin
        chk("c_hold", {29'd0, c2, c1, c0}, {29'd0, held});
      end
    end
  end

  task automatic ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2:0] c, output int unsigned lat);
    c   = (x > y) ? 3'b001 : ((x == y) ? 3'b010 : 3'b100);
    lat = D;
    for (int k = D - 1; k >= 0; k--) begin
      if (x[2*k +: 2] != y[2*k +: 2]) begin
        lat = D - k;
        break;
      end
    end
  endtask

  // Waits for IDLE, asserts start for one edge and queues the expectation.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [2:0] ec, input int unsigned el);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("idle_timeout", 32'd1, 32'd0);
    end else begin
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back('{c: ec, lat: el, t0: cyc});
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  logic [2:0]  ec;
  int unsigned el;
  logic [W-1:0] bv[11];

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_c", {29'd0, c2, c1, c0}, 32'd0);
    rst = 1'b0;

    // Equal operands: full scan, then verify outputs hold.
    issue(8'hA5, 8'hA5, 3'b010, 4);
    drain();
    repeat (2) @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    chk("hold_done", {31'd0, done}, 32'd0);
    chk("hold_c", {29'd0, c2, c1, c0}, 32'b010);

    // Early exit and late decisions.
    issue(8'hC0, 8'h40, 3'b001, 1);
    issue(8'h12, 8'h13, 3'b100, 4);
    issue(8'h13, 8'h12, 3'b001, 4);
    drain();

    // Start re-asserted during RUN with new operands must be ignored.
    issue(8'h00, 8'hFF, 3'b100, 1);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h3C;
    b     = 8'hC3;
    repeat (6) @(negedge clk);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);
    drain();

    // Reset two cycles into a compare aborts it.
    issue(8'h55, 8'h56, 3'b100, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_c", {29'd0, c2, c1, c0}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(8'h56, 8'h55, 3'b001, 4);
    drain();

    // Back-to-back sweep over digit-targeted operand pairs.
    for (int ai = 0; ai < 256; ai += 7) begin
      bv[0]  = W'(ai);
      bv[1]  = W'(ai) ^ 8'h01;
      bv[2]  = W'(ai) ^ 8'h03;
      bv[3]  = W'(ai) ^ 8'h04;
      bv[4]  = W'(ai) ^ 8'h0C;
      bv[5]  = W'(ai) ^ 8'h10;
      bv[6]  = W'(ai) ^ 8'h30;
      bv[7]  = W'(ai) ^ 8'h40;
      bv[8]  = W'(ai) ^ 8'hC0;
      bv[9]  = W'(ai) ^ 8'hFF;
      bv[10] = W'($urandom_range(255, 0));
      for (int bi = 0; bi < 11; bi++) begin
        ref_cmp(W'(ai), bv[bi], ec, el);
        issue(W'(ai), bv[bi], ec, el);
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
